// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Shift-add sequential multiplier. Two WIDTH-bit operands are multiplied over
// exactly WIDTH clock cycles into a 2*WIDTH-bit product. The product register
// only changes when an operation completes (or on reset), so a downstream
// seven-segment display never sees a partial sum.
//
// Ports:
//   clk      in   1        system clock, all state updates on the rising edge
//   rst      in   1        asynchronous reset, active-high
//   start    in   1        request a multiply; only looked at while IDLE
//   a        in   WIDTH    multiplicand, captured when start is accepted
//   b        in   WIDTH    multiplier, captured when start is accepted
//   busy     out  1        high while the RUN state is computing
//   done     out  1        one-cycle pulse in the cycle after product updates
//   product  out  2*WIDTH  last completed result
//
// Handshake: start is accepted on any rising edge where the block is IDLE
// (busy=0) and start=1, including the single cycle in which done is high, so
// back-to-back operations need no gap. While busy=1, start, a and b are
// ignored and nothing is queued. done rises on the edge that writes product
// and falls on the following edge.
//
// Optional feature, controlled by macro SEQ_MULT_SIGNED_EN:
//   defined   - a and b are two's complement; magnitudes are multiplied and
//               the result is negated at completion when the operand signs
//               differ. Latency is unchanged.
//   undefined - unsigned multiply only; no sign logic is built.
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // The counter must be able to hold WIDTH itself (its value after the last
    // RUN edge), hence one bit more than clog2(WIDTH).
    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q,   state_d;
    logic [2*WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]       mplier_q,  mplier_d;
    logic [2*WIDTH-1:0]     acc_q,     acc_d;
    logic [CW-1:0]          cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]     product_q, product_d;
    logic                   done_q,    done_d;

    // Operand magnitudes as captured on accept, and the accumulator value
    // including this cycle's conditional add.
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [2*WIDTH-1:0]     acc_sum;
    logic [2*WIDTH-1:0]     result;

`ifdef SEQ_MULT_SIGNED_EN
    logic                   sign_q, sign_d;
    logic                   sign_in;

    // Magnitude of a two's complement value. The most negative input (e.g.
    // 8'h80) negates to itself, whose unsigned reading is exactly its
    // magnitude, so WIDTH bits are enough.
    always_comb begin
        a_mag   = a[WIDTH-1] ? (~a + 1'b1) : a;
        b_mag   = b[WIDTH-1] ? (~b + 1'b1) : b;
        sign_in = a[WIDTH-1] ^ b[WIDTH-1];
    end

    always_comb begin
        result = sign_q ? (~acc_sum + 1'b1) : acc_sum;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end

    always_comb begin
        result = acc_sum;
    end
`endif

    // Add the shifted multiplicand when the current multiplier LSB is set.
    // The sum of WIDTH-bit magnitudes fits in 2*WIDTH bits, so no carry out.
    always_comb begin
        acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d    = sign_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
`ifdef SEQ_MULT_SIGNED_EN
                    sign_d   = sign_in;
`endif
                end
            end

            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Fixed iteration count: a zero multiplier does not end early,
                // so latency never depends on the data.
                if (cnt_q == LAST) begin
                    product_d = result;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

`ifdef SEQ_MULT_SIGNED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // behavioural model: an accepted operation finishes exactly W cycles later
  // with the arithmetic product; nothing else moves the outputs.
  // ---------------------------------------------------------------------------
  function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [2*W-1:0] sx, sy;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    r  = sx * sy;
`else
    r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
    return r;
  endfunction

  int             m_left = 0;
  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_prod = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) begin
        m_prod = m_pend;
        m_busy = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = mul_ref(a, b);
        m_left = W;
        m_busy = 1'b1;
      end
    end
  end

  // compare process: outputs are checked on every falling edge
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("product", product, m_prod);
  end

  // ---------------------------------------------------------------------------
  // driver tasks (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string name,
                        input logic [2*W-1:0] exp_p);
    int lat;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_busy"}, busy, 1'b1);
    wait_done(lat);
    check({name, "_lat"}, lat, W);
    check({name, "_prod"}, product, exp_p);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) cnt++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  logic [W-1:0] pick_tab[5];

  initial begin
    int lat, cnt, first_t, last_t, pulses;
    bit gap_ok;

    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_prod", product, 16'h0000);
    rst = 1'b0;
    tick();

    // FF * FF, product must be held afterwards
`ifdef SEQ_MULT_SIGNED_EN
    run_op(8'hFF, 8'hFF, "ff_ff", 16'h0001);
    count_done(5, cnt);
    check("ff_ff_hold", product, 16'h0001);
`else
    run_op(8'hFF, 8'hFF, "ff_ff", 16'hFE01);
    count_done(5, cnt);
    check("ff_ff_hold", product, 16'hFE01);
`endif
    check("ff_ff_no_extra_done", cnt, 0);

    // zero operand still takes the full latency
    run_op(8'h00, 8'h37, "zero", 16'h0000);
    tick();
    run_op(8'h0C, 8'h0A, "c_a", 16'h0078);
    tick();

    // start re-asserted during RUN is ignored
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'h01;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("ignore_lat", lat, W - 3);
    check("ignore_prod", product, 16'h03A8);
    count_done(15, cnt);
    check("ignore_no_second_done", cnt, 0);

    // reset in the middle of an operation
    a = 8'hFD;
    b = 8'h05;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", busy, 1'b0);
    check("midrst_prod", product, 16'h0000);
    rst = 1'b0;
    count_done(12, cnt);
    check("midrst_no_done", cnt, 0);
`ifdef SEQ_MULT_SIGNED_EN
    run_op(8'hFD, 8'h05, "fd_05", 16'hFFF1);
`else
    run_op(8'hFD, 8'h05, "fd_05", 16'h04F1);
`endif
    tick();

    // start held high: done every W+1 cycles, the first accepted at once
    a = 8'h02;
    b = 8'h03;
    start = 1'b1;
    pulses = 0;
    first_t = 0;
    last_t = 0;
    gap_ok = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (done) begin
        if (pulses == 0) first_t = t;
        else if (t - last_t != W + 1) gap_ok = 1'b0;
        last_t = t;
        pulses++;
      end
    end
    start = 1'b0;
    check("hold_first", first_t, W + 1);
    check("hold_pulses", pulses, 4);
    check("hold_gap", gap_ok, 1'b1);
    check("hold_prod", product, 16'h0006);
    wait_done(lat);
    tick();

    // most negative operand
`ifdef SEQ_MULT_SIGNED_EN
    run_op(8'h80, 8'h80, "m80_80", 16'h4000);
    run_op(8'h80, 8'h01, "m80_01", 16'hFF80);
`else
    run_op(8'h80, 8'h80, "m80_80", 16'h4000);
    run_op(8'h80, 8'h01, "m80_01", 16'h0080);
`endif
    tick();

    // randomized traffic, checked cycle by cycle against the model
    pick_tab[0] = 8'h00;
    pick_tab[1] = 8'hFF;
    pick_tab[2] = 8'h80;
    pick_tab[3] = 8'h01;
    pick_tab[4] = 8'h7F;
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom_range(0, 3) == 0) ? pick_tab[$urandom_range(0, 4)] : W'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? pick_tab[$urandom_range(0, 4)] : W'($urandom_range(0, 255));
      start = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    wait_done(lat);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Shift-add sequential multiplier. Two WIDTH-bit operands in, one 2*WIDTH-bit product out.
- Sits directly upstream of the 4-digit seven-segment display stage; product drives the display's 16-bit digit input (WIDTH=8).
- Product register holds the last completed result, so the display never shows partial sums.
- One clock domain; start/busy/done handshake with the operand source (switches/buttons).

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request multiply; sampled only in IDLE
a  input  WIDTH  multiplicand; latched on accepted start
b  input  WIDTH  multiplier; latched on accepted start
busy  output  1  high while computing (RUN state)
done  output  1  one-cycle pulse when product updates
product  output  2*WIDTH  last completed result; feeds display digit input

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, product=0, internal accumulator/operand/counter regs=0. Reset mid-computation discards the operation; no done pulse follows.
- States: IDLE, RUN.
- IDLE: done deasserts after its one pulse cycle. If start=1 at edge k: latch mcand={WIDTH zeros,a} (2*WIDTH wide), mplier=b, acc=0, cnt=0, state->RUN, busy=1. If start=0: hold.
- RUN, each edge: if mplier[0]=1 then acc<=acc+mcand (2*WIDTH-bit add, no overflow possible); mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
- On the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge, edge k+WIDTH): product<=final acc (including that cycle's add), done<=1, busy<=0, state->IDLE.
- Latency: start sampled at edge k -> product and done valid after edge k+WIDTH. Fixed, data-independent (zero operands do not terminate early).
- done is high for exactly one cycle. If start=1 in that same cycle, it is accepted (back-to-back ops; next done at +WIDTH).
- start while busy=1: ignored, no queuing. a/b changes during RUN: no effect.
- product changes only at completion or reset; holds between operations.
- cnt width = clog2(WIDTH)+1 bits; it does not wrap within an operation.

Optional Feature:
- Macro SEQ_MULT_SIGNED_EN.
- Defined: a, b are two's complement. On accept, latch |a|, |b| and sign = a[MSB]^b[MSB]. At completion, product <= sign ? -acc : acc (2*WIDTH-bit two's complement). Latency unchanged. The most-negative operand (8'h80) magnitude is 128, which is representable in the 2*WIDTH-bit path.
- Undefined: unsigned only; no sign logic synthesized.

Test Plan:
- Reset then a=8'hFF, b=8'hFF, start pulsed 1 cycle -> busy=1 for 8 cycles; done pulses after edge k+8; product=16'hFE01 and held afterwards.
- a=8'h00, b=8'h37 -> done still at k+8 (no early exit); product=16'h0000. Then a=8'h0C, b=8'h0A -> product=16'h0078.
- Run a=8'h12, b=8'h34, re-assert start with a=8'h01, b=8'h01 at k+3 -> ignored; product=16'h03A8; no second done.
- Start a=8'hFD, b=8'h05, assert rst at k+4 -> product=0, busy=0, done never pulses. Restart the same operands -> unsigned product=16'h04F1; with SEQ_MULT_SIGNED_EN, 16'hFFF1 (-15).
- Hold start=1 continuously with a=8'h02, b=8'h03 -> a done pulse every 9 cycles (8 RUN + 1 IDLE accept, except the first, which is accepted on the first edge); product=16'h0006.
- SEQ_MULT_SIGNED_EN: a=8'h80, b=8'h80 -> 16'h4000; a=8'h80, b=8'h01 -> 16'hFF80.
